// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply
// (MUL_BITS per cycle), restoring divide, accumulate, cancel, divide-by-zero flag.
module mdu_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic [2*WIDTH-1:0] hilo_acc_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_by_zero_o
);

   localparam int MUL_CYC = WIDTH / MUL_BITS;
   localparam int CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [CW-1:0] CNT_MUL_LAST = CW'(MUL_CYC - 1);
   localparam logic [CW-1:0] CNT_DIV_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [2:0]           op_r;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     op2_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   prod_r;
   logic [WIDTH-1:0]     rem_r;
   logic [WIDTH-1:0]     quot_r;
   logic [CW-1:0]        cnt_r;
   logic                 sign_q_r, sign_r_r, dz_r;
   logic [2*WIDTH-1:0]   result_r;
   logic                 ready_r, busy_r, dbz_r;

   logic                 signed_s, neg1_s, neg2_s, is_div_s, op2_zero_s, accept_s;
   logic [2*WIDTH-1:0]   mul_add_s, prod_step_s, prod_fix_s, fix_s;
   logic [WIDTH:0]       part_s, dvs_ext_s;
   logic [WIDTH-1:0]     rem_step_s, quot_fix_s, rem_fix_s;
   logic                 qbit_s;

   // Two's complement magnitude of a possibly negative operand; 2^(WIDTH-1) fits unsigned.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign signed_s   = ~op_i[0];
   assign neg1_s     = signed_s & opdata1_i[WIDTH-1];
   assign neg2_s     = signed_s & opdata2_i[WIDTH-1];
   assign is_div_s   = op_i[2] & op_i[1];
   assign op2_zero_s = (opdata2_i == '0);
   assign accept_s   = (state_r == S_IDLE) & start_i & ~annul_i;

   // Next-state logic; annul overrides everything, including a start in IDLE.
   always_comb begin
      state_s = state_r;
      if (annul_i) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_i) begin
                  if (is_div_s) begin
                     state_s = op2_zero_s ? S_FIX : S_DIV;
                  end else begin
                     state_s = S_MUL;
                  end
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_MUL:   state_s = (cnt_r == CNT_MUL_LAST) ? S_FIX : S_MUL;
            S_DIV:   state_s = (cnt_r == CNT_DIV_LAST) ? S_FIX : S_DIV;
            S_FIX:   state_s = S_DONE;
            S_DONE:  state_s = start_i ? S_DONE : S_IDLE;
            default: state_s = S_IDLE;
         endcase
      end
   end

   // Per-cycle multiply/divide step values and the final sign/accumulate fix-up.
   always_comb begin
      mul_add_s = '0;
      for (int j = 0; j < MUL_BITS; j++) begin
         if (op2_r[j]) begin
            mul_add_s = mul_add_s + (mcand_r << j);
         end else begin
            mul_add_s = mul_add_s;
         end
      end
      prod_step_s = prod_r + mul_add_s;

      part_s    = {rem_r, quot_r[WIDTH-1]};
      dvs_ext_s = {1'b0, op2_r};
      if (part_s >= dvs_ext_s) begin
         rem_step_s = WIDTH'(part_s - dvs_ext_s);
         qbit_s     = 1'b1;
      end else begin
         rem_step_s = part_s[WIDTH-1:0];
         qbit_s     = 1'b0;
      end

      prod_fix_s = sign_q_r ? -prod_r : prod_r;
      quot_fix_s = sign_q_r ? -quot_r : quot_r;
      rem_fix_s  = sign_r_r ? -rem_r  : rem_r;
      case (op_r)
         3'b000, 3'b001: fix_s = prod_fix_s;
         3'b010, 3'b011: fix_s = acc_r + prod_fix_s;
         3'b100, 3'b101: fix_s = acc_r - prod_fix_s;
         3'b110, 3'b111: fix_s = dz_r ? '0 : {rem_fix_s, quot_fix_s};
         default:        fix_s = prod_fix_s;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture at acceptance and iterative datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r     <= 3'b000;
         mcand_r  <= '0;
         op2_r    <= '0;
         acc_r    <= '0;
         prod_r   <= '0;
         rem_r    <= '0;
         quot_r   <= '0;
         cnt_r    <= '0;
         sign_q_r <= 1'b0;
         sign_r_r <= 1'b0;
         dz_r     <= 1'b0;
      end else if (accept_s) begin
         op_r     <= op_i;
         mcand_r  <= {{WIDTH{1'b0}}, mag_f(opdata1_i, neg1_s)};
         op2_r    <= mag_f(opdata2_i, neg2_s);
         acc_r    <= hilo_acc_i;
         prod_r   <= '0;
         rem_r    <= '0;
         quot_r   <= mag_f(opdata1_i, neg1_s);
         cnt_r    <= '0;
         sign_q_r <= neg1_s ^ neg2_s;
         sign_r_r <= neg1_s;
         dz_r     <= is_div_s & op2_zero_s;
      end else begin
         case (state_r)
            S_MUL: begin
               prod_r  <= prod_step_s;
               mcand_r <= mcand_r << MUL_BITS;
               op2_r   <= op2_r >> MUL_BITS;
               cnt_r   <= cnt_r + CNT_ONE;
            end
            S_DIV: begin
               rem_r  <= rem_step_s;
               quot_r <= {quot_r[WIDTH-2:0], qbit_s};
               cnt_r  <= cnt_r + CNT_ONE;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Registered outputs; result and flag only change on a completed FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_r <= '0;
         ready_r  <= 1'b0;
         busy_r   <= 1'b0;
         dbz_r    <= 1'b0;
      end else begin
         ready_r <= (state_s == S_DONE);
         busy_r  <= (state_s == S_MUL) | (state_s == S_DIV) | (state_s == S_FIX);
         if ((state_r == S_FIX) && !annul_i) begin
            result_r <= fix_s;
            dbz_r    <= dz_r;
         end else if (accept_s) begin
            dbz_r <= 1'b0;
         end else begin
            dbz_r <= dbz_r;
         end
      end
   end

   assign result_o      = result_r;
   assign ready_o       = ready_r;
   assign busy_o        = busy_r;
   assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, annul/reset sequences and random ops
// against an arithmetic reference, on a radix-2 and a radix-16 instance.
module tb_mdu_iter;

   logic        clk, rst, start_i, annul_i;
   logic [2:0]  op_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] hilo_acc_i;
   logic [63:0] result1, result4;
   logic        ready1, busy1, dz1, ready4, busy4, dz4;

   int n_checks = 0;
   int n_fail   = 0;

   mdu_iter #(.WIDTH(32), .MUL_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_acc_i(hilo_acc_i),
      .annul_i(annul_i), .result_o(result1), .ready_o(ready1), .busy_o(busy1),
      .div_by_zero_o(dz1));

   mdu_iter #(.WIDTH(32), .MUL_BITS(4)) dut4 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_acc_i(hilo_acc_i),
      .annul_i(annul_i), .result_o(result4), .ready_o(ready4), .busy_o(busy4),
      .div_by_zero_o(dz4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] acc;
      logic [63:0] res;
      logic        dz;
   } vec_t;

   vec_t tv[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Reference: signed/unsigned 64-bit arithmetic straight from the op definitions.
   function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     res, qv, rv;
      logic            dz;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      dz = 1'b0;
      res = 64'd0;
      case (op)
         3'd0: res = sa * sb;
         3'd1: res = ua * ub;
         3'd2: res = acc + sa * sb;
         3'd3: res = acc + ua * ub;
         3'd4: res = acc - sa * sb;
         3'd5: res = acc - ua * ub;
         default: begin
            if (b == 32'd0) begin
               dz = 1'b1;
            end else if (op == 3'd6) begin
               q = sa / sb; r = sa % sb;
               qv = q; rv = r;
               res = {rv[31:0], qv[31:0]};
            end else begin
               qv = ua / ub; rv = ua % ub;
               res = {rv[31:0], qv[31:0]};
            end
         end
      endcase
      return {dz, res};
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic dz, input int mul_bits);
      if (op[2] & op[1]) return dz ? 2 : 34;
      return 32 / mul_bits + 2;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'($urandom_range(0, 20));
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd0;
         default: return $urandom;
      endcase
   endfunction

   // One full transaction: start held through DONE, inputs scrambled while busy.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, input logic [63:0] exp_res,
                         input logic exp_dz, input string name);
      int lat1, lat4;
      @(negedge clk);
      op_i = op; opdata1_i = a; opdata2_i = b; hilo_acc_i = acc;
      start_i = 1'b1; annul_i = 1'b0;
      lat1 = 0; lat4 = 0;
      for (int e = 1; e <= 80; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            chk({name, "_dz_clear"}, {63'd0, dz1}, 64'd0);
            chk({name, "_busy"}, {63'd0, busy1}, 64'd1);
            op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
            hilo_acc_i = {$urandom, $urandom};
         end
         if (ready1 && lat1 == 0) lat1 = e;
         if (ready4 && lat4 == 0) lat4 = e;
         if (lat1 != 0 && lat4 != 0) break;
      end
      chk({name, "_res"}, result1, exp_res);
      chk({name, "_dz"}, {63'd0, dz1}, {63'd0, exp_dz});
      chk({name, "_lat"}, 64'(lat1), 64'(exp_lat(op, exp_dz, 1)));
      chk({name, "_res4"}, result4, exp_res);
      chk({name, "_lat4"}, 64'(lat4), 64'(exp_lat(op, exp_dz, 4)));
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_hold"}, {62'd0, ready1, busy1}, 64'd2);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({name, "_drop"}, {63'd0, ready1}, 64'd0);
   endtask

   initial begin
      logic [64:0] m;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] racc;
      bit          seen;

      tv[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0005, 64'd0,  64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
      tv[1]  = '{3'd4, 32'h0000_0003, 32'h0000_0004, 64'h10, 64'h0000_0000_0000_0004, 1'b0};
      tv[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,  64'hFFFF_FFFE_0000_0001, 1'b0};
      tv[3]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 64'd0,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      tv[4]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,  64'h0000_0000_8000_0000, 1'b0};
      tv[5]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 64'd0,  64'h0000_0000_0000_0000, 1'b1};
      tv[6]  = '{3'd7, 32'd100,       32'd7,         64'd0,  64'h0000_0002_0000_000E, 1'b0};
      tv[7]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 64'd0,  64'h4000_0000_0000_0000, 1'b0};
      tv[8]  = '{3'd2, 32'h8000_0000, 32'h7FFF_FFFF, 64'd1,  64'hC000_0000_8000_0001, 1'b0};
      tv[9]  = '{3'd5, 32'h0000_0001, 32'h0000_0001, 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      tv[10] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 64'd0,  64'h0000_0001_FFFF_FFFD, 1'b0};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0;
      opdata1_i = 32'd0; opdata2_i = 32'd0; hilo_acc_i = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_res", result1, 64'd0);
      chk("reset_flags", {60'd0, ready1, busy1, dz1, ready4}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++)
         run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].acc, tv[i].res, tv[i].dz,
                $sformatf("vec%0d", i));

      // Annul on edge 10 of a divide: back to IDLE, no ready, result untouched.
      @(negedge clk);
      op_i = 3'd7; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1;
      chk("annul_state", {62'd0, ready1, busy1}, 64'd0);
      chk("annul_res", result1, tv[10].res);
      @(posedge clk); #1;
      chk("annul_beats_start", {61'd0, ready1, busy1, busy4}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready1 || busy1) seen = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen}, 64'd0);
      chk("annul_res_kept", result1, tv[10].res);
      run_op(3'd7, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 1'b0, "post_annul");

      // Asynchronous reset in the middle of a multiply.
      @(negedge clk);
      op_i = 3'd0; opdata1_i = 32'd3; opdata2_i = 32'd5; start_i = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_mid_res", result1, 64'd0);
      chk("rst_mid_res4", result4, 64'd0);
      chk("rst_mid_flags", {60'd0, ready1, busy1, dz1, busy4}, 64'd0);
      @(negedge clk);
      rst = 1'b0; start_i = 1'b0;
      @(posedge clk); #1;
      chk("rst_idle", {62'd0, busy1, ready1}, 64'd0);
      run_op(3'd0, 32'd3, 32'd5, 64'd0, 64'd15, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         rop  = 3'($urandom);
         ra   = pick();
         rb   = pick();
         racc = {$urandom, $urandom};
         m    = model(rop, ra, rb, racc);
         run_op(rop, ra, rb, racc, m[63:0], m[64], $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit serving the execute stage for MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU.
- Replaces the single-cycle multiplier and separate divider with one shared shift-add / restoring-division datapath.
- Generalised in operand width and multiply radix; adds accumulate, cancel, and divide-by-zero flagging.
- Result is the full {HI,LO} value, which the execute stage forwards to the HI/LO write port.

Parameters:
- WIDTH, 32: operand width. Must be even and >= 8.
- MUL_BITS, 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4, and MUL_BITS must divide WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  level request; the execute stage holds it high until ready_o is seen.
- op_i  in  3  operation: 000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 DIV, 111 DIVU.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- hilo_acc_i  in  2*WIDTH  accumulator {HI,LO} for MADD/MSUB.
- annul_i  in  1  cancel, asserted on flush or exception.
- result_o  out  2*WIDTH  {HI,LO}; for divide it is {remainder, quotient}.
- ready_o  out  1  result valid.
- busy_o  out  1  operation in flight.
- div_by_zero_o  out  1  the divide in the DONE state had a zero divisor.

Behaviour:
- Reset (asynchronous): state=IDLE, result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0, iteration counter=0.

States:
- IDLE: ready_o=0, busy_o=0.
  - Accepts when start_i=1 and annul_i=0.
  - On acceptance, latches op, the operands and hilo_acc_i.
  - The stored operand magnitudes are the two's complement of the inputs when the op is signed and the input is negative; otherwise the raw inputs.
  - Records sign_q = op1 sign XOR op2 sign and sign_r = op1 sign, both for signed ops only.
  - Next state: MUL for ops 000-101. DIV for 110/111 with a nonzero divisor. FIX with dz=1 for 110/111 with divisor = 0.
- MUL: busy_o=1. Each cycle adds (multiplicand << shift) times the next MUL_BITS multiplier bits into a 2*WIDTH product register. Runs exactly WIDTH/MUL_BITS cycles, then FIX.
- DIV: busy_o=1. Restoring division, 1 quotient bit per cycle, on a {WIDTH+1}-bit partial remainder. Runs exactly WIDTH cycles, then FIX.
- FIX: busy_o=1, one cycle. Computes the final value as follows, then enters DONE:
  - Multiply: signed ops take p = -mag when sign_q=1. MULT/MULTU give p. MADD/MADDU give acc + p. MSUB/MSUBU give acc - p. All mod 2^(2*WIDTH).
  - Divide: q = -mag_q if sign_q. r = -mag_r if sign_r. result = {r, q}.
  - dz=1: result=0 and div_by_zero_o=1.
- DONE: ready_o=1, busy_o=0. result_o and div_by_zero_o are stable. Returns to IDLE when start_i=0 or annul_i=1. A new start is only accepted from IDLE.

Latency (from the accepting edge to the first cycle with ready_o=1):
- Multiply: WIDTH/MUL_BITS + 2 edges (WIDTH=32, MUL_BITS=1: 34 edges).
- Divide: WIDTH + 2 edges.
- Divide by zero: 2 edges.

Boundary conditions:
- annul_i=1 in any state: next state is IDLE. No ready_o pulse, and result_o keeps its previous value. Annul beats a simultaneous start.
- Signed minimum / -1 (DIV 0x80000000 / 0xFFFFFFFF): quotient wraps to 0x80000000, remainder 0. No flag.
- Signed minimum as a multiply operand: its magnitude 2^(WIDTH-1) must be handled exactly, using a WIDTH-bit unsigned magnitude.
- Operand or op changes while busy are ignored, since all inputs are latched at acceptance.
- result_o updates only at FIX→DONE and holds until the next FIX→DONE.
- div_by_zero_o clears at the next acceptance.
- rst asserted mid-operation: immediate return to the reset values.

Test Plan (WIDTH=32, MUL_BITS=1 unless noted):
- MULT 0xFFFFFFFF × 0x00000005 → ready_o high 34 edges after acceptance; result 0xFFFFFFFF_FFFFFFFB.
- MSUB, acc=0x00000000_00000010, 3 × 4 → result 0x00000000_00000004. With MUL_BITS=4, MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001 after 10 edges.
- DIV -7 (0xFFFFFFF9) / 2 → result 0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- DIVU 0x1234 / 0 → ready_o after 2 edges; result 0; div_by_zero_o=1; cleared on the next start.
- DIVU accepted, annul_i pulsed on edge 10 → IDLE next cycle, no ready_o, old result_o unchanged. A following DIVU 100/7 → 0x00000002_0000000E.
- rst pulsed asynchronously mid-MUL → all outputs 0 immediately. start_i held through DONE → ready_o stays high and no restart occurs until start_i drops.
